// File: rtl/vectored_interrupt_controller_if.sv
// Signal bundle between the IF-stage PC mux / pipeline control and the
// vectored interrupt controller.
interface vectored_interrupt_controller_if #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 12
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [PC_W-1:0]  PC;
    logic [6:0]       if_opcode;
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_mask;
    logic             gie;
    logic [1:0]       exe_correction;
    logic             if_prediction;
    logic             id_sel_pc;
    logic             if_clk_en;

    logic             sel_ISR;
    logic             ret_ISR;
    logic             ISR_en;
    logic             ISR_stall;
    logic [PC_W-1:0]  save_PC;
    logic [PC_W-1:0]  isr_addr;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] pending;

    modport master (
        output PC, if_opcode, irq, irq_mask, gie, exe_correction,
               if_prediction, id_sel_pc, if_clk_en,
        input  sel_ISR, ret_ISR, ISR_en, ISR_stall, save_PC, isr_addr,
               irq_id, pending
    );

    modport slave (
        input  PC, if_opcode, irq, irq_mask, gie, exe_correction,
               if_prediction, id_sel_pc, if_clk_en,
        output sel_ISR, ret_ISR, ISR_en, ISR_stall, save_PC, isr_addr,
               irq_id, pending
    );
endinterface

// File: rtl/vectored_interrupt_controller.sv
// Edge-latched, fixed-priority, single-level vectored interrupt controller
// that redirects IF-stage fetch only at pipeline-safe points.
module vectored_interrupt_controller #(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 12,
    parameter logic [PC_W-1:0] ISR_BASE   = 'h800,
    parameter int              VEC_STRIDE = 16,
    parameter logic [6:0]      RET_OPCODE = 7'b1110011
) (
    input logic clk,
    input logic nrst,
    vectored_interrupt_controller_if.slave bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [2:0] {IDLE, ARM, ENTER, ACTIVE, RETURN} state_t;

    state_t           state_reg, state_next;
    logic [N_IRQ-1:0] irq_q_reg, pending_reg, pending_next;
    logic [N_IRQ-1:0] rise, eligible;
    logic [PC_W-1:0]  save_pc_reg, isr_addr_reg, vec_addr;
    logic [ID_W-1:0]  irq_id_reg, winner;
    logic             safe, accept;

    assign rise     = bus.irq & ~irq_q_reg;
    assign eligible = pending_reg & bus.irq_mask & {N_IRQ{bus.gie}};
    assign safe     = bus.if_clk_en & (bus.exe_correction == 2'b00)
                    & ~bus.if_prediction & ~bus.id_sel_pc;
    assign accept   = (state_reg == ARM) && (eligible != '0) && safe;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    assign vec_addr = ISR_BASE + PC_W'(winner) * PC_W'(VEC_STRIDE);

    // A fresh edge on the bit being accepted must survive the clear.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pending
        assign pending_next[gi] = (pending_reg[gi] & ~(accept && (winner == ID_W'(gi))))
                                | rise[gi];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (eligible != '0) state_next = ARM;
            ARM: begin
                if (eligible == '0) state_next = IDLE;
                else if (safe)      state_next = ENTER;
            end
            ENTER:   state_next = ACTIVE;
            ACTIVE:  if (bus.if_clk_en && (bus.if_opcode == RET_OPCODE)) state_next = RETURN;
            RETURN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.sel_ISR   = 1'b0;
        bus.ret_ISR   = 1'b0;
        bus.ISR_en    = 1'b0;
        bus.ISR_stall = 1'b0;
        case (state_reg)
            ENTER: begin
                bus.sel_ISR   = 1'b1;
                bus.ISR_stall = 1'b1;
                bus.ISR_en    = 1'b1;
            end
            ACTIVE: bus.ISR_en = 1'b1;
            RETURN: begin
                bus.ret_ISR   = 1'b1;
                bus.ISR_stall = 1'b1;
                bus.ISR_en    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            irq_q_reg    <= '0;
            pending_reg  <= '0;
            save_pc_reg  <= '0;
            isr_addr_reg <= '0;
            irq_id_reg   <= '0;
        end else begin
            irq_q_reg   <= bus.irq;
            pending_reg <= pending_next;
            if (accept) begin
                save_pc_reg  <= bus.PC;
                isr_addr_reg <= vec_addr;
                irq_id_reg   <= winner;
            end
        end
    end

    assign bus.save_PC  = save_pc_reg;
    assign bus.isr_addr = isr_addr_reg;
    assign bus.irq_id   = irq_id_reg;
    assign bus.pending  = pending_reg;
endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural reference model.
module tb_vectored_interrupt_controller;
    localparam logic [6:0] RET = 7'b1110011;
    localparam int M_IDLE = 0, M_ARM = 1, M_ENTER = 2, M_ACTIVE = 3, M_RETURN = 4;

    logic clk;
    logic nrst;
    int   n_checks = 0;
    int   n_fail   = 0;

    vectored_interrupt_controller_if #(.N_IRQ(4), .PC_W(12)) bus ();

    vectored_interrupt_controller #(
        .N_IRQ(4), .PC_W(12), .ISR_BASE(12'h800), .VEC_STRIDE(16), .RET_OPCODE(RET)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic [6:0]  op;
        logic        clken;
        logic [11:0] pc;
        logic        sel, ret, en, stall;
        logic [3:0]  pend;
        logic [1:0]  id;
        logic [11:0] addr, save;
    } vec_t;

    vec_t tbl[17];

    // Reference model state
    int m_mode;
    bit m_pend[4];
    bit m_prev[4];
    int m_id, m_addr, m_save;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_safe();
        bus.exe_correction = 2'b00;
        bus.if_prediction  = 1'b0;
        bus.id_sel_pc      = 1'b0;
        bus.if_clk_en      = 1'b1;
    endtask

    task automatic apply_block(input int kind);
        set_safe();
        case (kind)
            0: bus.exe_correction = 2'b01;
            1: bus.id_sel_pc      = 1'b1;
            2: bus.if_prediction  = 1'b1;
            default: bus.if_clk_en = 1'b0;
        endcase
    endtask

    task automatic finish_isr();
        // From ENTER: ACTIVE, RETURN, IDLE
        step();
        bus.if_opcode = RET; bus.if_clk_en = 1'b1;
        step();
        check("ret_pulse", bus.ret_ISR, 1);
        bus.if_opcode = 7'h00;
        step();
        check("back_idle_en", bus.ISR_en, 0);
    endtask

    task automatic blocked_entry(input int kind);
        set_safe();
        bus.irq = 4'b0000;
        step();
        apply_block(kind);
        bus.irq = 4'b1000;
        step();
        check($sformatf("blk%0d_pend", kind), bus.pending, 4'b1000);
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("blk%0d_sel_c%0d", kind, c), bus.sel_ISR, 0);
            check($sformatf("blk%0d_en_c%0d", kind, c), bus.ISR_en, 0);
        end
        set_safe();
        bus.PC = 12'h0A0;
        step();
        check($sformatf("blk%0d_sel_after", kind), bus.sel_ISR, 1);
        check($sformatf("blk%0d_id", kind), bus.irq_id, 3);
        check($sformatf("blk%0d_addr", kind), bus.isr_addr, 12'h830);
        check($sformatf("blk%0d_save", kind), bus.save_PC, 12'h0A0);
        finish_isr();
    endtask

    task automatic model_edge();
        int  first;
        bit  safe;
        first = -1;
        for (int i = 0; i < 4; i++)
            if (first < 0 && m_pend[i] && bus.irq_mask[i] && bus.gie) first = i;
        safe = bus.if_clk_en && bus.exe_correction == 2'b00 && !bus.if_prediction && !bus.id_sel_pc;
        case (m_mode)
            M_IDLE:   if (first >= 0) m_mode = M_ARM;
            M_ARM: begin
                if (first < 0) m_mode = M_IDLE;
                else if (safe) begin
                    m_mode = M_ENTER;
                    m_save = int'(bus.PC);
                    m_id   = first;
                    m_addr = (2048 + first * 16) % 4096;
                    m_pend[first] = 1'b0;
                end
            end
            M_ENTER:  m_mode = M_ACTIVE;
            M_ACTIVE: if (bus.if_clk_en && bus.if_opcode == RET) m_mode = M_RETURN;
            default:  m_mode = M_IDLE;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (bus.irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev[i] = bus.irq[i];
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [3:0] mp;
        for (int i = 0; i < 4; i++) mp[i] = m_pend[i];
        check($sformatf("rnd%0d_sel", cyc), bus.sel_ISR, (m_mode == M_ENTER) ? 1 : 0);
        check($sformatf("rnd%0d_ret", cyc), bus.ret_ISR, (m_mode == M_RETURN) ? 1 : 0);
        check($sformatf("rnd%0d_en", cyc), bus.ISR_en, (m_mode >= M_ENTER) ? 1 : 0);
        check($sformatf("rnd%0d_stall", cyc), bus.ISR_stall,
              (m_mode == M_ENTER || m_mode == M_RETURN) ? 1 : 0);
        check($sformatf("rnd%0d_pend", cyc), bus.pending, mp);
        check($sformatf("rnd%0d_id", cyc), bus.irq_id, m_id);
        check($sformatf("rnd%0d_addr", cyc), bus.isr_addr, m_addr);
        check($sformatf("rnd%0d_save", cyc), bus.save_PC, m_save);
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 7'h00, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 12'h000, 12'h000};
        tbl[1]  = '{4'b0001, 7'h00, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 12'h000, 12'h000};
        tbl[2]  = '{4'b0001, 7'h00, 1'b1, 12'h010, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 12'h800, 12'h010};
        tbl[3]  = '{4'b0111, 7'h00, 1'b1, 12'h010, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 2'd0, 12'h800, 12'h010};
        tbl[4]  = '{4'b0111, RET,   1'b1, 12'h010, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 2'd0, 12'h800, 12'h010};
        tbl[5]  = '{4'b0111, 7'h00, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 2'd0, 12'h800, 12'h010};
        tbl[6]  = '{4'b0111, 7'h00, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 2'd0, 12'h800, 12'h010};
        tbl[7]  = '{4'b0111, 7'h00, 1'b1, 12'h020, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[8]  = '{4'b0111, 7'h00, 1'b1, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[9]  = '{4'b0111, RET,   1'b0, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[10] = '{4'b0111, RET,   1'b1, 12'h020, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[11] = '{4'b0111, 7'h00, 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[12] = '{4'b0111, 7'h00, 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd1, 12'h810, 12'h020};
        tbl[13] = '{4'b0111, 7'h00, 1'b1, 12'h030, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd2, 12'h820, 12'h030};
        tbl[14] = '{4'b0000, 7'h00, 1'b1, 12'h030, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 12'h820, 12'h030};
        tbl[15] = '{4'b0000, RET,   1'b1, 12'h030, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd2, 12'h820, 12'h030};
        tbl[16] = '{4'b0000, 7'h00, 1'b1, 12'h030, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 12'h820, 12'h030};

        nrst = 1'b0;
        bus.PC = 12'h010; bus.if_opcode = 7'h00; bus.irq = 4'b0000;
        bus.irq_mask = 4'b1111; bus.gie = 1'b1;
        set_safe();
        #39;
        check("rst_sel", bus.sel_ISR, 0);
        check("rst_ret", bus.ret_ISR, 0);
        check("rst_en", bus.ISR_en, 0);
        check("rst_stall", bus.ISR_stall, 0);
        check("rst_pend", bus.pending, 0);
        check("rst_save", bus.save_PC, 0);
        check("rst_addr", bus.isr_addr, 0);
        check("rst_id", bus.irq_id, 0);
        #1 nrst = 1'b1;

        // Directed vector table
        for (int r = 0; r < 17; r++) begin
            bus.irq = tbl[r].irq; bus.if_opcode = tbl[r].op;
            bus.if_clk_en = tbl[r].clken; bus.PC = tbl[r].pc;
            step();
            check($sformatf("vec%0d_sel", r), bus.sel_ISR, tbl[r].sel);
            check($sformatf("vec%0d_ret", r), bus.ret_ISR, tbl[r].ret);
            check($sformatf("vec%0d_en", r), bus.ISR_en, tbl[r].en);
            check($sformatf("vec%0d_stall", r), bus.ISR_stall, tbl[r].stall);
            check($sformatf("vec%0d_pend", r), bus.pending, tbl[r].pend);
            check($sformatf("vec%0d_id", r), bus.irq_id, tbl[r].id);
            check($sformatf("vec%0d_addr", r), bus.isr_addr, tbl[r].addr);
            check($sformatf("vec%0d_save", r), bus.save_PC, tbl[r].save);
            $display("vec %0d: irq=%b sel=%b ret=%b en=%b pend=%b id=%0d addr=%h",
                     r, tbl[r].irq, bus.sel_ISR, bus.ret_ISR, bus.ISR_en,
                     bus.pending, bus.irq_id, bus.isr_addr);
        end

        // Each unsafe condition holds off entry
        for (int k = 0; k < 4; k++) begin
            blocked_entry(k);
            $display("blocked entry kind %0d done", k);
        end

        // Masked source stays pending, entry after unmask
        set_safe(); bus.irq = 4'b0000; step();
        bus.irq_mask = 4'b1110; bus.irq = 4'b0001; step();
        check("mask_pend", bus.pending, 4'b0001);
        step(); step();
        check("mask_no_sel", bus.sel_ISR, 0);
        check("mask_no_en", bus.ISR_en, 0);
        check("mask_pend_kept", bus.pending, 4'b0001);
        bus.irq_mask = 4'b1111; bus.PC = 12'h044; step();
        check("unmask_arm_sel", bus.sel_ISR, 0);
        step();
        check("unmask_sel", bus.sel_ISR, 1);
        check("unmask_addr", bus.isr_addr, 12'h800);
        check("unmask_save", bus.save_PC, 12'h044);
        finish_isr();
        $display("mask sequence done");

        // gie dropped in ARM returns to IDLE, pending kept
        bus.irq = 4'b0000; step();
        bus.exe_correction = 2'b01; bus.irq = 4'b0001; step();
        step();
        bus.gie = 1'b0; step();
        check("gie_pend", bus.pending, 4'b0001);
        check("gie_sel", bus.sel_ISR, 0);
        step();
        bus.gie = 1'b1; bus.exe_correction = 2'b00; step();
        check("gie_rearm_sel0", bus.sel_ISR, 0);
        step();
        check("gie_rearm_sel1", bus.sel_ISR, 1);
        step();
        check("gie_active_en", bus.ISR_en, 1);
        $display("gie sequence done");

        // Return opcode ignored while IF stalled; edges latched during ISR
        bus.if_opcode = RET; bus.if_clk_en = 1'b0; bus.irq = 4'b0011; step();
        check("stall_ret_no", bus.ret_ISR, 0);
        check("stall_ret_en", bus.ISR_en, 1);
        check("isr_latch_pend", bus.pending, 4'b0010);
        bus.if_opcode = 7'h00; bus.if_clk_en = 1'b1; step();
        check("isr_hold_en", bus.ISR_en, 1);
        check("isr_hold_sel", bus.sel_ISR, 0);
        bus.if_opcode = RET; step();
        check("late_ret", bus.ret_ISR, 1);
        check("late_ret_pend", bus.pending, 4'b0010);
        bus.if_opcode = 7'h00; step();
        check("late_idle_en", bus.ISR_en, 0);
        step();
        check("late_arm_sel", bus.sel_ISR, 0);
        step();
        check("late_sel", bus.sel_ISR, 1);
        check("late_id", bus.irq_id, 1);
        check("late_addr", bus.isr_addr, 12'h810);
        step();
        bus.irq = 4'b0111; step();
        check("pre_rst_en", bus.ISR_en, 1);
        check("pre_rst_pend", bus.pending, 4'b0100);

        // Asynchronous reset mid-ISR
        #1 nrst = 1'b0;
        #1;
        check("arst_en", bus.ISR_en, 0);
        check("arst_sel", bus.sel_ISR, 0);
        check("arst_ret", bus.ret_ISR, 0);
        check("arst_stall", bus.ISR_stall, 0);
        check("arst_pend", bus.pending, 0);
        check("arst_save", bus.save_PC, 0);
        check("arst_addr", bus.isr_addr, 0);
        check("arst_id", bus.irq_id, 0);
        $display("async reset sequence done");
        #3 nrst = 1'b1;

        // Randomized traffic against the reference model
        nrst = 1'b0;
        bus.irq = 4'b0000; bus.irq_mask = 4'b1111; bus.gie = 1'b1; set_safe();
        bus.if_opcode = 7'h00;
        step();
        #2 nrst = 1'b1;
        m_mode = M_IDLE; m_id = 0; m_addr = 0; m_save = 0;
        for (int i = 0; i < 4; i++) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] flip;
            for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 7) == 0);
            bus.irq = bus.irq ^ flip;
            if ($urandom_range(0, 31) == 0) bus.irq_mask = 4'($urandom);
            bus.gie            = ($urandom_range(0, 19) != 0);
            bus.exe_correction = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.if_prediction  = ($urandom_range(0, 7) == 0);
            bus.id_sel_pc      = ($urandom_range(0, 7) == 0);
            bus.if_clk_en      = ($urandom_range(0, 7) != 0);
            bus.if_opcode      = ($urandom_range(0, 2) == 0) ? RET : 7'($urandom_range(0, 114));
            bus.PC             = 12'($urandom);
            step();
            model_edge();
            model_compare(cyc);
        end
        $display("random phase: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vectored_interrupt_controller.md
Name: vectored_interrupt_controller

Overview:
- Parametrised successor to the single-line interrupt_controller of the pipelined RV32IMC core.
- Accepts N_IRQ maskable interrupt lines and latches rising edges as pending bits.
- Selects the highest-priority unmasked pending source and waits for a pipeline-safe fetch point before redirecting fetch to a per-source vector.
- Saves the return PC, detects the ISR return opcode and restores; one level, no nesting. Sits beside the IF stage PC mux.

Parameters:
- N_IRQ, 4, number of interrupt lines (1..16); index 0 is highest priority.
- PC_W, 12, width of PC, save_PC and isr_addr.
- ISR_BASE, 12'h800, vector address of source 0.
- VEC_STRIDE, 16, byte distance between consecutive vectors.
- RET_OPCODE, 7'b1110011, IF opcode recognised as ISR return.
- ID_W (localparam), max(1, clog2(N_IRQ)).

Ports:
- clk  in  1  core clock.
- nrst  in  1  async active-low reset.
- PC  in  PC_W  current IF-stage PC.
- if_opcode  in  7  opcode of the instruction in IF.
- irq  in  N_IRQ  level interrupt requests; rising edge = event.
- irq_mask  in  N_IRQ  1 = source enabled.
- gie  in  1  global interrupt enable.
- exe_correction  in  2  EXE branch correction; nonzero = flush in flight.
- if_prediction  in  1  IF branch predicted taken.
- id_sel_pc  in  1  ID-stage jump redirect.
- if_clk_en  in  1  IF stage advancing (not stalled).
- sel_ISR  out  1  select isr_addr as next PC (1 cycle).
- ret_ISR  out  1  select save_PC as next PC (1 cycle).
- ISR_en  out  1  processor is inside an ISR.
- ISR_stall  out  1  pipeline bubble request.
- save_PC  out  PC_W  captured return address.
- isr_addr  out  PC_W  vector of the accepted source.
- irq_id  out  ID_W  index of the accepted source.
- pending  out  N_IRQ  pending register (debug).

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, pending=0, edge-detect history=0.
  - save_PC=0, isr_addr=0, irq_id=0.
  - All 1-bit outputs 0.
- Edge detect: irq_q <= irq each cycle. Rising edge on bit i sets pending[i] on the next edge.
- Pending clear: pending[i] clears only on acceptance. A simultaneous new edge and clear on the same bit leaves the bit set.
- Masking: the mask never clears pending. eligible = pending & irq_mask & {N_IRQ{gie}}.
- Winner: lowest set index of eligible, re-evaluated every cycle while in ARM.
- Safe point: safe = if_clk_en & (exe_correction==2'b00) & ~if_prediction & ~id_sel_pc.
- FSM, all outputs Moore-decoded from registered state:
  - IDLE: if eligible≠0 -> ARM.
  - ARM: if eligible==0 (masked or gie dropped) -> IDLE. Else if safe, go to ENTER and in the same edge:
    - save_PC <= PC
    - irq_id <= winner
    - isr_addr <= ISR_BASE + winner*VEC_STRIDE (mod 2^PC_W)
    - pending[winner] <= 0
    - Otherwise stay in ARM.
  - ENTER: sel_ISR=1, ISR_stall=1, ISR_en=1, for exactly 1 cycle -> ACTIVE.
  - ACTIVE: ISR_en=1. If if_clk_en & (if_opcode==RET_OPCODE) -> RETURN. Opcode ignored while if_clk_en=0.
  - RETURN: ret_ISR=1, ISR_stall=1, ISR_en=1, for 1 cycle -> IDLE.
- Latency:
  - Edge on irq to sel_ISR: minimum 3 cycles (pending set, ARM, ENTER), plus any unsafe cycles spent in ARM.
  - Return opcode to ret_ISR: 1 cycle.
- Edges arriving during ENTER/ACTIVE/RETURN are latched and serviced via IDLE->ARM after return. There is no back-to-back skip of IDLE.
- save_PC and isr_addr hold their values until the next acceptance.
- Reset mid-ISR: everything returns to reset values and pending interrupts are lost.

Test Plan:
- Reset hold 40 ns, then irq=0001, mask=1111, gie=1, safe inputs, PC=12'h010 -> sel_ISR pulses 1 cycle on the 3rd edge after the irq rise; save_PC=12'h010, isr_addr=12'h800, irq_id=0, pending=0.
- irq=0110 in the same cycle -> source 1 accepted, isr_addr=12'h810. After RET_OPCODE with if_clk_en=1, ret_ISR pulses 1 cycle, then IDLE→ARM→ENTER with irq_id=2, isr_addr=12'h820.
- Edge on irq[3] with exe_correction=2'b01 for 4 cycles, then 0 -> state stays ARM and sel_ISR=0 for those 4 cycles. sel_ISR asserts 1 cycle after the correction clears. Repeat with id_sel_pc=1, if_prediction=1 and if_clk_en=0: each blocks entry.
- irq[0] edge with irq_mask[0]=0 -> no entry, pending[0]=1. Set mask[0]=1 -> entry follows. gie dropped while in ARM -> returns to IDLE with pending kept.
- In ACTIVE, drive RET_OPCODE with if_clk_en=0 -> no ret_ISR. Raise irq[1] edge -> pending[1]=1, not serviced until after RETURN.
- Assert nrst=0 during ACTIVE -> all outputs, pending and save_PC are 0 immediately, without waiting for a clock edge.
